// File: rtl/tdm_demux_if.sv
// tdm_demux_if: bus bundle between a TDM sample source and the demultiplexer.
//   din        : TDM sample word (WIDTH bits)
//   din_valid  : din holds a sample this cycle
//   frame_sync : qualified by din_valid, marks the slot-0 sample
//   dout       : last complete frame, channel k at [k*WIDTH +: WIDTH]
//   dout_valid : 1-cycle strobe, dout updated this cycle
//   sync_err   : 1-cycle strobe, framing error detected
// master = sample source / frame consumer, slave = demultiplexer.
interface tdm_demux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic [WIDTH-1:0]          din;
  logic                      din_valid;
  logic                      frame_sync;
  logic [WIDTH*CHANNELS-1:0] dout;
  logic                      dout_valid;
  logic                      sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  dout, dout_valid, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output dout, dout_valid, sync_err
  );
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: receive-side TDM channel demultiplexer.
// Assigns each valid sample to its channel slot, presents a complete frame as
// CHANNELS parallel words with a 1-cycle dout_valid strobe, flags loss of frame
// alignment with a 1-cycle sync_err strobe and re-acquires lock by itself.
// Ports:
//   clk   : single clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : tdm_demux_if.slave (din/din_valid/frame_sync in, dout/dout_valid/sync_err out)
module tdm_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  tdm_demux_if.slave bus
);

  localparam int                SLOT_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                    state_reg, state_next;
  logic [SLOT_W-1:0]         slot_reg, slot_next;
  logic [WIDTH-1:0]          shadow_reg [CHANNELS];
  logic [WIDTH*CHANNELS-1:0] dout_reg, dout_next;
  logic                      dout_valid_reg, dout_valid_next;
  logic                      sync_err_reg, sync_err_next;

  // Per-cycle capture decision shared by the FSM and the shadow registers.
  logic                      capture;
  logic [SLOT_W-1:0]         cap_slot;
  logic [WIDTH*CHANNELS-1:0] frame_word;

  // Completed frame: earlier slots come from the shadow registers, the last
  // slot comes straight from din so the frame is published on its own edge.
  generate
    for (genvar gi = 0; gi < CHANNELS - 1; gi++) begin : g_frame
      assign frame_word[gi*WIDTH +: WIDTH] = shadow_reg[gi];
    end
  endgenerate
  assign frame_word[(CHANNELS-1)*WIDTH +: WIDTH] = bus.din;

  always_comb begin
    state_next      = state_reg;
    slot_next       = slot_reg;
    dout_next       = dout_reg;
    dout_valid_next = 1'b0;
    sync_err_next   = 1'b0;
    capture         = 1'b0;
    cap_slot        = slot_reg;

    if (bus.din_valid) begin
      unique case (state_reg)
        HUNT: begin
          // Unsynchronised samples are dropped silently while hunting.
          if (bus.frame_sync) begin
            capture    = 1'b1;
            cap_slot   = '0;
            state_next = LOCK;
          end
        end
        LOCK: begin
          if (bus.frame_sync) begin
            // A sync mid-frame restarts the frame; the partial one is lost.
            capture  = 1'b1;
            cap_slot = '0;
            if (slot_reg != '0) begin
              sync_err_next = 1'b1;
            end
          end else if (slot_reg != '0) begin
            capture = 1'b1;
          end else begin
            // Slot 0 expected a sync marker: alignment lost.
            sync_err_next = 1'b1;
            state_next    = HUNT;
          end
        end
        default: state_next = HUNT;
      endcase
    end

    if (capture) begin
      if (cap_slot == LAST_SLOT) begin
        dout_next       = frame_word;
        dout_valid_next = 1'b1;
        slot_next       = '0;
      end else begin
        slot_next = cap_slot + SLOT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= HUNT;
      slot_reg       <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      slot_reg       <= slot_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      sync_err_reg   <= sync_err_next;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_shadow
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg[gi] <= '0;
        end else if (capture && (cap_slot == SLOT_W'(gi))) begin
          shadow_reg[gi] <= bus.din;
        end
      end
    end
  endgenerate

  assign bus.dout       = dout_reg;
  assign bus.dout_valid = dout_valid_reg;
  assign bus.sync_err   = sync_err_reg;

endmodule
